// File: rtl/seg_pkg.sv
// Shared constants and the active-low seven-segment glyph table for the scanned display.
package seg_pkg;

    localparam int NIBBLE_W = 4;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Segment order and polarity follow the board wiring; 0 lights a segment.
    function automatic logic [6:0] glyph(input logic [NIBBLE_W-1:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0: pattern = 7'b0001000;
            4'h1: pattern = 7'b1101101;
            4'h2: pattern = 7'b0100010;
            4'h3: pattern = 7'b0100100;
            4'h4: pattern = 7'b1000101;
            4'h5: pattern = 7'b0010100;
            4'h6: pattern = 7'b0010000;
            4'h7: pattern = 7'b0101101;
            4'h8: pattern = 7'b0000000;
            4'h9: pattern = 7'b0000100;
            4'hA: pattern = 7'b0000001;
            4'hB: pattern = 7'b1010000;
            4'hC: pattern = 7'b0011010;
            4'hD: pattern = 7'b1100000;
            4'hE: pattern = 7'b0010010;
            default: pattern = 7'b0010011;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational hex nibble to active-low segment pattern lookup.
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [6:0]          pattern
);

    assign pattern = glyph(nibble);

endmodule

// File: rtl/seg_scan_display.sv
// Multi-digit seven-segment scanner with guard gap and tear-free shadow loading.
// Optional SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int SLOT_CYCLES   = 50000,
    parameter int GUARD_CYCLES  = 500,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [NIBBLE_W*DIGITS-1:0] NUM,
    input  logic [DIGITS-1:0]          DP_IN,
    input  logic [DIGITS-1:0]          BLANK,
    input  logic                       LOAD,
    output logic [6:0]                 SEG,
    output logic                       DP,
    output logic [DIGITS-1:0]          AN,
    output logic                       SCAN_TICK
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     LAST_CNT = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0]     GUARD_C  = CW'(GUARD_CYCLES);
    localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NIBBLE_W-1:0] num_in [DIGITS];
    logic [NIBBLE_W-1:0] shadow_num_q [DIGITS];
    logic [NIBBLE_W-1:0] shadow_num_d [DIGITS];
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;

    // Value of the lit digit, frozen at the start of its drive phase.
    logic [NIBBLE_W-1:0] cur_num_q, cur_num_d;
    logic                cur_dp_q, cur_dp_d;
    logic                cur_blank_q, cur_blank_d;

    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                tick_q, tick_d;

    logic [DIGITS-1:0]   an_sel;
    logic [DIGITS-1:0]   lz_blank;
    logic [DIGITS-1:0]   eff_blank;
    logic [6:0]          glyph_pat;
    logic                slot_last;
    logic                drive_start;
    logic                in_guard;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign num_in[gi] = NUM[gi*NIBBLE_W +: NIBBLE_W];
            assign an_sel[gi] = (idx_q == IW'(gi));
        end
    endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Walk down from the most significant digit while every digit seen is zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run & (shadow_num_q[i] == '0);
            lz_blank[i] = zero_run & (i != 0);
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign eff_blank = shadow_blank_q | lz_blank;

    always_comb begin
        shadow_num_d   = shadow_num_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        if (LOAD) begin
            shadow_num_d   = num_in;
            shadow_dp_d    = DP_IN;
            shadow_blank_d = BLANK;
        end
    end

    always_comb begin
        slot_last = (cnt_q == LAST_CNT);
        cnt_d     = slot_last ? '0 : cnt_q + CW'(1);
        idx_d     = idx_q;
        tick_d    = 1'b0;
        if (slot_last) begin
            if (idx_q == LAST_IDX) begin
                idx_d  = '0;
                tick_d = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_comb begin
        drive_start = (cnt_q == GUARD_C);
        in_guard    = (cnt_q < GUARD_C);
        cur_num_d   = cur_num_q;
        cur_dp_d    = cur_dp_q;
        cur_blank_d = cur_blank_q;
        if (drive_start) begin
            cur_num_d   = shadow_num_q[idx_q];
            cur_dp_d    = shadow_dp_q[idx_q];
            cur_blank_d = eff_blank[idx_q];
        end
    end

    seg_glyph_rom u_glyph_rom (
        .nibble  (cur_num_d),
        .pattern (glyph_pat)
    );

    always_comb begin
        seg_d = GLYPH_BLANK;
        dp_d  = 1'b1;
        an_d  = AN_OFF;
        if (!in_guard) begin
            an_d = AN_ACTIVE_LOW ? ~an_sel : an_sel;
            if (!cur_blank_d) begin
                seg_d = glyph_pat;
                dp_d  = ~cur_dp_d;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            cur_num_q      <= '0;
            cur_dp_q       <= 1'b0;
            cur_blank_q    <= 1'b0;
            seg_q          <= GLYPH_BLANK;
            dp_q           <= 1'b1;
            an_q           <= AN_OFF;
            tick_q         <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                shadow_num_q[i] <= '0;
            end
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            cur_num_q      <= cur_num_d;
            cur_dp_q       <= cur_dp_d;
            cur_blank_q    <= cur_blank_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            an_q           <= an_d;
            tick_q         <= tick_d;
            for (int i = 0; i < DIGITS; i++) begin
                shadow_num_q[i] <= shadow_num_d[i];
            end
        end
    end

    assign SEG       = seg_q;
    assign DP        = dp_q;
    assign AN        = an_q;
    assign SCAN_TICK = tick_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: a cycle model pushes expected pins, tasks pop and compare.
module tb_seg_scan_display;

    localparam int DIG   = 4;
    localparam int SLOT  = 8;
    localparam int GUARD = 2;
    localparam int SCAN  = DIG * SLOT;

    localparam logic [6:0] GLYPHS [16] = '{
        7'b0001000, 7'b1101101, 7'b0100010, 7'b0100100,
        7'b1000101, 7'b0010100, 7'b0010000, 7'b0101101,
        7'b0000000, 7'b0000100, 7'b0000001, 7'b1010000,
        7'b0011010, 7'b1100000, 7'b0010010, 7'b0010011
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] num = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        scan_tick;

    int tests = 0;
    int fails = 0;

    // Expected pins packed as {seg, dp, an, tick}.
    logic [12:0] sb_q [$];

    int         m = 0;
    logic [3:0] sh_num [DIG] = '{default: 4'h0};
    logic [3:0] sh_dp = '0;
    logic [3:0] sh_blank = '0;
    logic [3:0] cur_num = '0;
    logic       cur_dp = 1'b0;
    logic       cur_blank = 1'b0;
    int         mpos;
    int         mdig;
    logic       mtick;
    logic       zrun;
    logic [3:0] an_exp;

    seg_scan_display #(
        .DIGITS        (DIG),
        .SLOT_CYCLES   (SLOT),
        .GUARD_CYCLES  (GUARD),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .NUM       (num),
        .DP_IN     (dp_in),
        .BLANK     (blank),
        .LOAD      (load),
        .SEG       (seg),
        .DP        (dp),
        .AN        (an),
        .SCAN_TICK (scan_tick)
    );

    always #5 clk = ~clk;

    // Model: state m is the m-th clocked state since reset; the pins after the next edge reflect it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m        = 0;
            sh_dp    = '0;
            sh_blank = '0;
            for (int i = 0; i < DIG; i++) sh_num[i] = '0;
            cur_num   = '0;
            cur_dp    = 1'b0;
            cur_blank = 1'b0;
            sb_q.delete();
        end else begin
            mpos  = m % SLOT;
            mdig  = (m / SLOT) % DIG;
            mtick = ((m % SCAN) == SCAN - 1);
            if (mpos == GUARD) begin
                cur_num   = sh_num[mdig];
                cur_dp    = sh_dp[mdig];
                cur_blank = sh_blank[mdig];
`ifdef SEG_LEADING_ZERO_BLANK_EN
                zrun = 1'b1;
                for (int j = mdig; j < DIG; j++) zrun = zrun & (sh_num[j] == 4'h0);
                if (mdig != 0 && zrun) cur_blank = 1'b1;
`endif
            end
            an_exp = ~(4'b0001 << mdig);
            if (mpos < GUARD)
                sb_q.push_back({7'b1111111, 1'b1, 4'b1111, mtick});
            else if (cur_blank)
                sb_q.push_back({7'b1111111, 1'b1, an_exp, mtick});
            else
                sb_q.push_back({GLYPHS[cur_num], ~cur_dp, an_exp, mtick});
            if (load) begin
                for (int i = 0; i < DIG; i++) sh_num[i] = num[i*4 +: 4];
                sh_dp    = dp_in;
                sh_blank = blank;
            end
            m = m + 1;
        end
    end

    task automatic test_reset();
        logic [12:0] obs, exp_v;
        repeat (3) @(negedge clk);
        tests++; if (seg !== 7'b1111111) begin fails++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        tests++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp got=%b exp=1", dp); end
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL reset_an got=%b exp=1111", an); end
        tests++; if (scan_tick !== 1'b0) begin fails++; $display("FAIL reset_tick got=%b exp=0", scan_tick); end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            obs = {seg, dp, an, scan_tick};
            tests++;
            if (sb_q.size() == 0) begin fails++; $display("FAIL reset_sb_empty cycle=%0d", i); end
            else begin
                exp_v = sb_q.pop_front();
                if (obs !== exp_v) begin fails++; $display("FAIL reset_scan cycle=%0d got=%h exp=%h", i, obs, exp_v); end
            end
            if (i == 1) begin
                tests++; if (an !== 4'b1111 || seg !== 7'b1111111) begin fails++; $display("FAIL reset_guard got an=%b seg=%b exp an=1111 seg=1111111", an, seg); end
            end
            if (i == 2 || i == 7) begin
                tests++; if (an !== 4'b1110 || seg !== 7'b0001000) begin fails++; $display("FAIL reset_digit0 cycle=%0d got an=%b seg=%b exp an=1110 seg=0001000", i, an, seg); end
            end
        end
    endtask

    task automatic test_hex_scan();
        logic [12:0] obs, exp_v;
        int ticks = 0;
        num = 16'hA3F7; dp_in = 4'b0010; blank = 4'b0000; load = 1'b1;
        for (int i = 0; i < 2 * SCAN; i++) begin
            @(negedge clk);
            load = 1'b0;
            obs = {seg, dp, an, scan_tick};
            tests++;
            if (sb_q.size() == 0) begin fails++; $display("FAIL hex_sb_empty cycle=%0d", i); end
            else begin
                exp_v = sb_q.pop_front();
                if (obs !== exp_v) begin fails++; $display("FAIL hex_scan cycle=%0d got=%h exp=%h", i, obs, exp_v); end
            end
            if (scan_tick === 1'b1) ticks++;
            if (i >= SLOT && an === 4'b1101) begin
                tests++; if (seg !== 7'b0010011 || dp !== 1'b0) begin fails++; $display("FAIL hex_digit1 got seg=%b dp=%b exp seg=0010011 dp=0", seg, dp); end
            end
            if (i >= SLOT && an === 4'b0111) begin
                tests++; if (seg !== 7'b0000001 || dp !== 1'b1) begin fails++; $display("FAIL hex_digit3 got seg=%b dp=%b exp seg=0000001 dp=1", seg, dp); end
            end
        end
        tests++; if (ticks !== 2) begin fails++; $display("FAIL hex_tick_count got=%0d exp=2", ticks); end
    endtask

    task automatic test_midslot_load();
        logic [12:0] obs, exp_v;
        int k;
        k = (2 * SLOT + 5 - (m % SCAN) + SCAN) % SCAN;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            obs = {seg, dp, an, scan_tick};
            tests++;
            if (sb_q.size() == 0) begin fails++; $display("FAIL midload_sb_empty cycle=%0d", i); end
            else begin
                exp_v = sb_q.pop_front();
                if (obs !== exp_v) begin fails++; $display("FAIL midload_wait cycle=%0d got=%h exp=%h", i, obs, exp_v); end
            end
        end
        num = 16'h1234; dp_in = 4'b0000; blank = 4'b0000; load = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            load = 1'b0;
            obs = {seg, dp, an, scan_tick};
            tests++;
            if (sb_q.size() == 0) begin fails++; $display("FAIL midload_sb_empty2 cycle=%0d", i); end
            else begin
                exp_v = sb_q.pop_front();
                if (obs !== exp_v) begin fails++; $display("FAIL midload_scan cycle=%0d got=%h exp=%h", i, obs, exp_v); end
            end
            if (i < 3) begin
                tests++; if (an !== 4'b1011 || seg !== 7'b0100100) begin fails++; $display("FAIL midload_old_digit2 cycle=%0d got an=%b seg=%b exp an=1011 seg=0100100", i, an, seg); end
            end
            if (i >= SLOT && an === 4'b1011) begin
                tests++; if (seg !== 7'b0100010) begin fails++; $display("FAIL midload_new_digit2 got=%b exp=0100010", seg); end
            end
            if (an === 4'b0111) begin
                tests++; if (seg !== 7'b1101101) begin fails++; $display("FAIL midload_new_digit3 got=%b exp=1101101", seg); end
            end
        end
    endtask

    task automatic test_blank();
        logic [12:0] obs, exp_v;
        int hits = 0;
        num = 16'h1234; dp_in = 4'b0100; blank = 4'b0100; load = 1'b1;
        for (int i = 0; i < 2 * SCAN; i++) begin
            @(negedge clk);
            load = 1'b0;
            obs = {seg, dp, an, scan_tick};
            tests++;
            if (sb_q.size() == 0) begin fails++; $display("FAIL blank_sb_empty cycle=%0d", i); end
            else begin
                exp_v = sb_q.pop_front();
                if (obs !== exp_v) begin fails++; $display("FAIL blank_scan cycle=%0d got=%h exp=%h", i, obs, exp_v); end
            end
            if (i >= SLOT && an === 4'b1011) begin
                hits++;
                tests++; if (seg !== 7'b1111111 || dp !== 1'b1) begin fails++; $display("FAIL blank_digit2 got seg=%b dp=%b exp seg=1111111 dp=1", seg, dp); end
            end
            if (i >= SLOT && an === 4'b1110) begin
                tests++; if (seg !== 7'b1000101) begin fails++; $display("FAIL blank_digit0 got=%b exp=1000101", seg); end
            end
        end
        tests++; if (hits == 0) begin fails++; $display("FAIL blank_anode_driven got=0 exp>0"); end
    endtask

    task automatic test_leading_zero();
        logic [12:0] obs, exp_v;
        for (int pass = 0; pass < 2; pass++) begin
            num = (pass == 0) ? 16'h0050 : 16'h0000; dp_in = '0; blank = '0; load = 1'b1;
            for (int i = 0; i < 2 * SCAN; i++) begin
                @(negedge clk);
                load = 1'b0;
                obs = {seg, dp, an, scan_tick};
                tests++;
                if (sb_q.size() == 0) begin fails++; $display("FAIL lzb_sb_empty cycle=%0d", i); end
                else begin
                    exp_v = sb_q.pop_front();
                    if (obs !== exp_v) begin fails++; $display("FAIL lzb_scan pass=%0d cycle=%0d got=%h exp=%h", pass, i, obs, exp_v); end
                end
                if (i >= SLOT && an === 4'b1110) begin
                    tests++; if (seg !== 7'b0001000) begin fails++; $display("FAIL lzb_digit0 got=%b exp=0001000", seg); end
                end
`ifdef SEG_LEADING_ZERO_BLANK_EN
                if (i >= SLOT && (an === 4'b0111 || an === 4'b1011)) begin
                    tests++; if (seg !== 7'b1111111) begin fails++; $display("FAIL lzb_upper_blank an=%b got=%b exp=1111111", an, seg); end
                end
                if (i >= SLOT && an === 4'b1101) begin
                    tests++;
                    if (seg !== ((pass == 0) ? 7'b0010100 : 7'b1111111)) begin fails++; $display("FAIL lzb_digit1 pass=%0d got=%b", pass, seg); end
                end
`else
                if (i >= SLOT && (an === 4'b0111 || an === 4'b1011)) begin
                    tests++; if (seg !== 7'b0001000) begin fails++; $display("FAIL lzb_upper_shown an=%b got=%b exp=0001000", an, seg); end
                end
`endif
            end
        end
    endtask

    task automatic test_reset_midslot();
        logic [12:0] obs, exp_v;
        int k;
        k = (SLOT + 4 - (m % SCAN) + SCAN) % SCAN;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            obs = {seg, dp, an, scan_tick};
            tests++;
            if (sb_q.size() == 0) begin fails++; $display("FAIL rstmid_sb_empty cycle=%0d", i); end
            else begin
                exp_v = sb_q.pop_front();
                if (obs !== exp_v) begin fails++; $display("FAIL rstmid_wait cycle=%0d got=%h exp=%h", i, obs, exp_v); end
            end
        end
        tests++; if (an !== 4'b1101) begin fails++; $display("FAIL rstmid_on_digit1 got=%b exp=1101", an); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (seg !== 7'b1111111 || dp !== 1'b1 || an !== 4'b1111 || scan_tick !== 1'b0)
            begin fails++; $display("FAIL rstmid_async got seg=%b dp=%b an=%b tick=%b exp 1111111 1 1111 0", seg, dp, an, scan_tick); end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            obs = {seg, dp, an, scan_tick};
            tests++;
            if (sb_q.size() == 0) begin fails++; $display("FAIL rstmid_sb_empty2 cycle=%0d", i); end
            else begin
                exp_v = sb_q.pop_front();
                if (obs !== exp_v) begin fails++; $display("FAIL rstmid_scan cycle=%0d got=%h exp=%h", i, obs, exp_v); end
            end
            if (i < 2) begin
                tests++; if (an !== 4'b1111) begin fails++; $display("FAIL rstmid_guard cycle=%0d got=%b exp=1111", i, an); end
            end else if (i < SLOT) begin
                tests++; if (an !== 4'b1110 || seg !== 7'b0001000) begin fails++; $display("FAIL rstmid_digit0 cycle=%0d got an=%b seg=%b exp an=1110 seg=0001000", i, an, seg); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex_scan();
        test_midslot_load();
        test_blank();
        test_leading_zero();
        test_reset_midslot();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
